// File: rtl/hilo_muldiv_sequencer_pkg.sv
// ============================================================================
//  Module   : hilo_muldiv_sequencer_pkg
//  Purpose  : Funct codes, sequencer state encoding and HI/LO-class decode
//             for the multi-cycle multiply/divide unit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package hilo_muldiv_sequencer_pkg;

    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } md_state_e;

    function automatic logic isHiLoFunct(input logic [5:0] f);
        logic r;
        case (f)
            ALU_MFHI, ALU_MTHI, ALU_MFLO, ALU_MTLO,
            ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
// ============================================================================
//  Module   : hilo_muldiv_sequencer
//  Purpose  : HI/LO register owner; multi-cycle shift-add multiply and
//             restoring divide with a one-cycle sign fixup.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hilo_muldiv_sequencer
    import hilo_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issueValid,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] operandA,
    input  logic [DATA_WIDTH-1:0] operandB,
    output logic                  stall,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] readData,
    output logic [DATA_WIDTH-1:0] hiOut,
    output logic [DATA_WIDTH-1:0] loOut,
    output logic                  divByZero
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    md_state_e               state_q;
    logic                    busy_q;
    logic                    div_zero_q;
    logic [DATA_WIDTH-1:0]   hi_q;
    logic [DATA_WIDTH-1:0]   lo_q;
    logic [DATA_WIDTH-1:0]   opnd_q;     // multiplicand or divisor magnitude
    logic [DATA_WIDTH-1:0]   raw_a_q;    // unmodified dividend for divide-by-zero
    logic [CNT_W-1:0]        cnt_q;
    logic                    neg_q;
    logic                    rem_neg_q;
    logic                    b_zero_q;
    logic                    op_div_q;

    logic                    hilo_class_w;
    logic                    accept_w;
    logic                    signed_op_w;
    logic                    a_neg_w;
    logic                    b_neg_w;
    logic [DATA_WIDTH-1:0]   a_mag_w;
    logic [DATA_WIDTH-1:0]   b_mag_w;

    assign hilo_class_w = isHiLoFunct(funct);
    assign stall        = issueValid & hilo_class_w & busy_q;
    assign accept_w     = issueValid & hilo_class_w & ~busy_q;

    assign signed_op_w  = (funct == ALU_MULT) || (funct == ALU_DIV);
    assign a_neg_w      = signed_op_w & operandA[DATA_WIDTH-1];
    assign b_neg_w      = signed_op_w & operandB[DATA_WIDTH-1];
    assign a_mag_w      = a_neg_w ? -operandA : operandA;
    assign b_mag_w      = b_neg_w ? -operandB : operandB;

    // Multiply step: conditionally add multiplicand into HI, then shift {carry,HI,LO} right
    logic [DATA_WIDTH:0]     mul_sum_w;
    logic [DATA_WIDTH-1:0]   mul_hi_d;
    logic [DATA_WIDTH-1:0]   mul_lo_d;

    assign mul_sum_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi_d  = mul_sum_w[DATA_WIDTH:1];
    assign mul_lo_d  = {mul_sum_w[0], lo_q[DATA_WIDTH-1:1]};

    // Divide step: partial remainder shifted left with next dividend bit, trial subtract
    logic [DATA_WIDTH:0]     div_rem_w;
    logic                    div_ge_w;
    logic [DATA_WIDTH-1:0]   div_hi_d;
    logic [DATA_WIDTH-1:0]   div_lo_d;

    assign div_rem_w = {hi_q, lo_q[DATA_WIDTH-1]};
    assign div_ge_w  = div_rem_w >= {1'b0, opnd_q};
    assign div_hi_d  = div_ge_w ? (div_rem_w[DATA_WIDTH-1:0] - opnd_q)
                                : div_rem_w[DATA_WIDTH-1:0];
    assign div_lo_d  = {lo_q[DATA_WIDTH-2:0], div_ge_w};

    logic [2*DATA_WIDTH-1:0] prod_w;
    logic [2*DATA_WIDTH-1:0] prod_fix_w;
    logic [DATA_WIDTH-1:0]   quo_fix_w;
    logic [DATA_WIDTH-1:0]   rem_fix_w;

    assign prod_w     = {hi_q, lo_q};
    assign prod_fix_w = neg_q ? -prod_w : prod_w;
    assign quo_fix_w  = neg_q ? -lo_q : lo_q;
    assign rem_fix_w  = rem_neg_q ? -hi_q : hi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            raw_a_q    <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            b_zero_q   <= 1'b0;
            op_div_q   <= 1'b0;
        end else begin
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        case (funct)
                            ALU_MTHI: hi_q <= operandA;
                            ALU_MTLO: lo_q <= operandA;
                            ALU_MULT, ALU_MULTU: begin
                                state_q  <= MUL;
                                busy_q   <= 1'b1;
                                cnt_q    <= CNT_LAST;
                                neg_q    <= a_neg_w ^ b_neg_w;
                                op_div_q <= 1'b0;
                                hi_q     <= '0;
                                lo_q     <= b_mag_w;
                                opnd_q   <= a_mag_w;
                            end
                            ALU_DIV, ALU_DIVU: begin
                                state_q   <= DIV;
                                busy_q    <= 1'b1;
                                cnt_q     <= CNT_LAST;
                                neg_q     <= a_neg_w ^ b_neg_w;
                                rem_neg_q <= a_neg_w;
                                b_zero_q  <= (operandB == '0);
                                raw_a_q   <= operandA;
                                op_div_q  <= 1'b1;
                                hi_q      <= '0;
                                lo_q      <= a_mag_w;
                                opnd_q    <= b_mag_w;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    hi_q <= mul_hi_d;
                    lo_q <= mul_lo_d;
                    if (cnt_q == '0) state_q <= FIXUP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                DIV: begin
                    hi_q <= div_hi_d;
                    lo_q <= div_lo_d;
                    if (cnt_q == '0) state_q <= FIXUP;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIXUP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!op_div_q) begin
                        {hi_q, lo_q} <= prod_fix_w;
                    end else if (b_zero_q) begin
                        hi_q       <= raw_a_q;
                        lo_q       <= '1;
                        div_zero_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix_w;
                        lo_q <= quo_fix_w;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        readData = '0;
        if (accept_w && funct == ALU_MFHI) readData = hi_q;
        if (accept_w && funct == ALU_MFLO) readData = lo_q;
    end

    assign busy      = busy_q;
    assign hiOut     = hi_q;
    assign loOut     = lo_q;
    assign divByZero = div_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv_sequencer.sv
// ============================================================================
//  Module   : tb_hilo_muldiv_sequencer
//  Purpose  : Self-checking bench for the HI/LO multiply/divide sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hilo_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic         clk = 1'b0;
    logic         rst;
    logic         issueValid;
    logic [5:0]   funct;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         stall;
    logic         busy;
    logic [W-1:0] readData;
    logic [W-1:0] hiOut;
    logic [W-1:0] loOut;
    logic         divByZero;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    hilo_muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issueValid),
        .funct      (funct),
        .operandA   (operandA),
        .operandB   (operandB),
        .stall      (stall),
        .busy       (busy),
        .readData   (readData),
        .hiOut      (hiOut),
        .loOut      (loOut),
        .divByZero  (divByZero)
    );

    typedef struct packed {
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs [8] = '{
        '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0},
        '{F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0},
        '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0},
        '{F_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1},
        '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0},
        '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0},
        '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0},
        '{F_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1}
    };

    // Reference result as {divByZero, HI, LO} from plain integer arithmetic
    function automatic logic [2*W:0] model(input logic [5:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint         sa;
        longint         sb;
        logic [2*W-1:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        if ((f == F_DIV || f == F_DIVU) && b == '0)
            return {1'b1, a, {W{1'b1}}};
        case (f)
            F_MULTU: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            F_MULT:  p = 64'(sa * sb);
            F_DIVU:  p = {a % b, a / b};
            default: p = {32'(sa % sb), 32'(sa / sb)};
        endcase
        return {1'b0, p};
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        issueValid = 1'b1;
        funct      = f;
        operandA   = a;
        operandB   = b;
        @(posedge clk); #1;
        issueValid = 1'b0;
        funct      = F_ADD;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; issueValid = 1'b0; funct = F_ADD; operandA = '0; operandB = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (hiOut !== '0) $display("FAIL reset_hi: got %h expected 0", hiOut); else pass_cnt++;
        chk_cnt++; if (loOut !== '0) $display("FAIL reset_lo: got %h expected 0", loOut); else pass_cnt++;
        chk_cnt++; if (divByZero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", divByZero); else pass_cnt++;
        issueValid = 1'b1; funct = F_MFHI;
        #1;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_cnt++;
        chk_cnt++; if (readData !== '0) $display("FAIL reset_mfhi: got %h expected 0", readData); else pass_cnt++;
        issueValid = 1'b0; funct = F_ADD;
        @(posedge clk); #1;
    endtask

    task automatic test_directed_ops;
        int n;
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b);
            wait_idle(n);
            chk_cnt++; if (n != W + 1) $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, n, W + 1); else pass_cnt++;
            chk_cnt++; if (hiOut !== vecs[i].hi) $display("FAIL dir%0d_hi: got %h expected %h", i, hiOut, vecs[i].hi); else pass_cnt++;
            chk_cnt++; if (loOut !== vecs[i].lo) $display("FAIL dir%0d_lo: got %h expected %h", i, loOut, vecs[i].lo); else pass_cnt++;
            chk_cnt++; if (divByZero !== vecs[i].dbz) $display("FAIL dir%0d_dbz: got %b expected %b", i, divByZero, vecs[i].dbz); else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++; if (divByZero !== 1'b0) $display("FAIL dir%0d_dbz_pulse: got %b expected 0", i, divByZero); else pass_cnt++;
        end
    endtask

    task automatic test_random_ops;
        logic [5:0]   ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W:0] exp;
        int           n;
        for (int i = 0; i < 30; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = W'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(f, a, b);
            issue(f, a, b);
            wait_idle(n);
            chk_cnt++; if (n != W + 1) $display("FAIL rnd%0d_busy_cycles: got %0d expected %0d", i, n, W + 1); else pass_cnt++;
            chk_cnt++; if (hiOut !== exp[2*W-1:W]) $display("FAIL rnd%0d_hi f=%h a=%h b=%h: got %h expected %h", i, f, a, b, hiOut, exp[2*W-1:W]); else pass_cnt++;
            chk_cnt++; if (loOut !== exp[W-1:0]) $display("FAIL rnd%0d_lo f=%h a=%h b=%h: got %h expected %h", i, f, a, b, loOut, exp[W-1:0]); else pass_cnt++;
            chk_cnt++; if (divByZero !== exp[2*W]) $display("FAIL rnd%0d_dbz: got %b expected %b", i, divByZero, exp[2*W]); else pass_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_moves;
        logic [W-1:0] hi_m;
        logic [W-1:0] lo_m;
        logic [W-1:0] v;
        hi_m = hiOut;
        lo_m = loOut;
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            if (i % 2 == 0) begin issue(F_MTHI, v, ~v); hi_m = v; end
            else            begin issue(F_MTLO, v, ~v); lo_m = v; end
            chk_cnt++; if (busy !== 1'b0) $display("FAIL mv%0d_busy: got %b expected 0", i, busy); else pass_cnt++;
            chk_cnt++; if (hiOut !== hi_m) $display("FAIL mv%0d_hi: got %h expected %h", i, hiOut, hi_m); else pass_cnt++;
            chk_cnt++; if (loOut !== lo_m) $display("FAIL mv%0d_lo: got %h expected %h", i, loOut, lo_m); else pass_cnt++;
            issueValid = 1'b1; funct = (i % 2 == 0) ? F_MFLO : F_MFHI;
            #1;
            chk_cnt++; if (readData !== ((i % 2 == 0) ? lo_m : hi_m)) $display("FAIL mv%0d_mf: got %h expected %h", i, readData, (i % 2 == 0) ? lo_m : hi_m); else pass_cnt++;
            funct = F_ADD;
            #1;
            chk_cnt++; if (readData !== '0) $display("FAIL mv%0d_rd_other: got %h expected 0", i, readData); else pass_cnt++;
            issueValid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_mflo;
        int n;
        issue(F_MULTU, 32'd6, 32'd7);
        issueValid = 1'b1; funct = F_ADD;
        #1;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL stall_add: got %b expected 0", stall); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("FAIL stall_busy: got %b expected 1", busy); else pass_cnt++;
        @(posedge clk); #1;
        funct = F_MFLO;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk_cnt++; if (n != W) $display("FAIL stall_cycles: got %0d expected %0d", n, W); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL stall_end_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (readData !== 32'h2A) $display("FAIL stall_mflo_data: got %h expected 0000002a", readData); else pass_cnt++;
        issueValid = 1'b0; funct = F_ADD;
        @(posedge clk); #1;
        chk_cnt++; if (loOut !== 32'h2A || busy !== 1'b0) $display("FAIL stall_after: got lo=%h busy=%b expected lo=0000002a busy=0", loOut, busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n;
        issue(F_DIVU, 32'd100, 32'd7);
        issueValid = 1'b1; funct = F_MULT; operandA = 32'hFFFFFFFB; operandB = 32'd9;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk_cnt++; if (n != W + 1) $display("FAIL b2b_stall_cycles: got %0d expected %0d", n, W + 1); else pass_cnt++;
        chk_cnt++; if (hiOut !== 32'd2 || loOut !== 32'd14) $display("FAIL b2b_first: got hi=%h lo=%h expected hi=00000002 lo=0000000e", hiOut, loOut); else pass_cnt++;
        @(posedge clk); #1;
        issueValid = 1'b0; funct = F_ADD;
        wait_idle(n);
        chk_cnt++; if (n != W + 1) $display("FAIL b2b_busy_cycles: got %0d expected %0d", n, W + 1); else pass_cnt++;
        chk_cnt++; if (hiOut !== 32'hFFFFFFFF || loOut !== 32'hFFFFFFD3) $display("FAIL b2b_second: got hi=%h lo=%h expected hi=ffffffff lo=ffffffd3", hiOut, loOut); else pass_cnt++;
    endtask

    task automatic test_reset_abort;
        issue(F_MTHI, 32'h1234, 32'h0);
        chk_cnt++; if (hiOut !== 32'h1234) $display("FAIL abort_mthi: got %h expected 00001234", hiOut); else pass_cnt++;
        issue(F_MULT, 32'h00012345, 32'h00000777);
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        issueValid = 1'b1; funct = F_MFHI;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (hiOut !== '0 || loOut !== '0) $display("FAIL abort_hilo: got hi=%h lo=%h expected 0", hiOut, loOut); else pass_cnt++;
        chk_cnt++; if (stall !== 1'b0) $display("FAIL abort_stall: got %b expected 0", stall); else pass_cnt++;
        chk_cnt++; if (divByZero !== 1'b0) $display("FAIL abort_dbz: got %b expected 0", divByZero); else pass_cnt++;
        issueValid = 1'b0; funct = F_ADD;
        repeat (3) begin @(posedge clk); #1; end
        chk_cnt++; if (busy !== 1'b0 || hiOut !== '0 || loOut !== '0) $display("FAIL abort_stays_idle: got busy=%b hi=%h lo=%h expected 0", busy, hiOut, loOut); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed_ops();
        test_stall_mflo();
        test_back_to_back();
        test_moves();
        test_random_ops();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Executes MULT, MULTU, DIV and DIVU over many cycles; services MTHI, MTLO, MFHI and MFLO.
- Sits beside the ALU in execute and is driven by the same funct field the Control decoder passes through for NON_IMMEDIATE_ALU opcodes.
- Raises a stall to the pipeline whenever a HI/LO-class instruction arrives while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- issueValid  input  1  an R-type instruction is in execute this cycle.
- funct  input  6  funct field of that instruction.
- operandA  input  DATA_WIDTH  rs value (multiplicand / dividend / MTHI/MTLO source).
- operandB  input  DATA_WIDTH  rt value (multiplier / divisor).
- stall  output  1  combinational; pipeline must hold the instruction this cycle.
- busy  output  1  registered; an operation is in flight.
- readData  output  DATA_WIDTH  combinational; HI for MFHI, LO for MFLO, 0 otherwise.
- hiOut  output  DATA_WIDTH  current HI register.
- loOut  output  DATA_WIDTH  current LO register.
- divByZero  output  1  registered; one-cycle pulse when a DIV/DIVU with divisor 0 completes.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, HI=0, LO=0, counter=0, busy=0, divByZero=0. Reset mid-operation aborts it with no HI/LO update.
- HI/LO-class funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - All other functs are ignored; they never stall.
- stall = issueValid & HI/LO-class funct & busy.
- Acceptance: an instruction is accepted when issueValid & HI/LO-class funct & !stall.
- MTHI/MTLO accepted: HI (or LO) = operandA at that edge; no busy.
- MFHI/MFLO accepted: readData = HI (or LO) in the same cycle; no state change.
- States are IDLE, MUL, DIV, FIXUP.
- MULT/MULTU/DIV/DIVU accepted in IDLE:
  - Latch operand magnitudes. For signed ops take the absolute value of each operand; unsigned ops use operands as-is.
  - Latch the sign flags and set counter = DATA_WIDTH-1.
  - Next state is MUL or DIV.
- MUL: one shift-add iteration per cycle into the 64-bit {HI,LO} accumulator. After the counter=0 iteration, go to FIXUP.
- DIV: one restoring-division iteration per cycle (remainder in the HI working register, quotient in the LO working register). After the counter=0 iteration, go to FIXUP.
- FIXUP (1 cycle), then IDLE. At the exit edge HI/LO are written:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Divisor 0: HI = operandA as latched (raw, not magnitude), LO = all ones, divByZero pulses for one cycle. No sign fixup.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (falls out of the magnitude algorithm; no special case).
- Latency:
  - busy rises the cycle after acceptance and stays high for exactly DATA_WIDTH+1 cycles (32 MUL/DIV + 1 FIXUP).
  - HI/LO hold final values in the first cycle busy=0.
- Intermediate HI/LO working values are not architecturally visible. hiOut/loOut may show partial values while busy=1; consumers must not sample them then.
- A stalled MFHI/MFLO is presented unchanged each cycle. It is accepted in the first cycle busy=0 and returns the final result that same cycle.
- A non-HI/LO instruction during busy proceeds without stall; the operation continues undisturbed.

Decomposition:
- ALUFunctCodesPackage gains ALU_MFHI, ALU_MTHI, ALU_MFLO, ALU_MTLO, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU if not already present.
- New MulDivPackage holds the state enum (IDLE, MUL, DIV, FIXUP) and the isHiLoFunct decode function.
- Single module. Counter, sign flags and iteration datapath are inline; no sub-module needed.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU 0x64 / 0 -> HI=0x00000064, LO=0xFFFFFFFF; divByZero high for exactly one cycle.
- MULTU 6×7, then MFLO held with issueValid the next cycle -> stall=1 for 32 cycles, stall=0 with readData=0x2A when busy falls. An ADD issued while busy -> stall=0.
- MTHI 0x1234 then MULT started, with rst asserted at iteration 10 -> next cycle busy=0, HI=LO=0, stall=0, divByZero=0.
